// File: rtl/dual_nand4_pkg.sv
// Shared constants for the dual 4-input NAND block (7420 equivalent).
package dual_nand4_pkg;

  // Default width of each debug toggle counter.
  localparam int unsigned CntWDefault = 16;

  // Reset value of the registered outputs: NAND of idle-low inputs.
  localparam logic RegRstVal = 1'b1;

endpackage : dual_nand4_pkg

// File: rtl/dual_nand4_nand4.sv
// Single 4-input NAND gate. Purely combinational, no clock or reset.
module dual_nand4_nand4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  // Output is low only when all four inputs are high. A defined 0 on any input forces y to 1.
  always_comb begin
    y = ~(a & b & c & d);
  end

endmodule : dual_nand4_nand4

// File: rtl/dual_nand4.sv
// Dual 4-input NAND (7420 equivalent) with a clocked observation stage.
// The combinational outputs p1y/p2y never depend on clk or reset.
// Optional debug toggle counters are compiled in with `define DUAL_NAND4_TOGGLE_CNT_EN.
module dual_nand4
  import dual_nand4_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p1a,
  input  logic             p1b,
  input  logic             p1c,
  input  logic             p1d,
  input  logic             p2a,
  input  logic             p2b,
  input  logic             p2c,
  input  logic             p2d,
  output logic             p1y,
  output logic             p2y,
  output logic             p1y_q,
  output logic             p2y_q
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] p1_tog_cnt,
  output logic [CNT_W-1:0] p2_tog_cnt
`endif
);

  dual_nand4_nand4 u_gate1 (
    .a (p1a),
    .b (p1b),
    .c (p1c),
    .d (p1d),
    .y (p1y)
  );

  dual_nand4_nand4 u_gate2 (
    .a (p2a),
    .b (p2b),
    .c (p2c),
    .d (p2d),
    .y (p2y)
  );

  // Registered copies of both gate outputs, one cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1y_q <= RegRstVal;
      p2y_q <= RegRstVal;
    end else begin
      p1y_q <= p1y;
      p2y_q <= p2y;
    end
  end

`ifdef DUAL_NAND4_TOGGLE_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] p1_cnt_q, p1_cnt_d;
  logic [CNT_W-1:0] p2_cnt_q, p2_cnt_d;

  // A toggle is a change between the live output and its registered copy at this edge.
  // cnt_clr discards any toggle on the same edge; counters saturate instead of wrapping.
  always_comb begin
    p1_cnt_d = p1_cnt_q;
    p2_cnt_d = p2_cnt_q;
    if (cnt_clr) begin
      p1_cnt_d = '0;
      p2_cnt_d = '0;
    end else begin
      if ((p1y != p1y_q) && (p1_cnt_q != CntMax)) begin
        p1_cnt_d = p1_cnt_q + 1'b1;
      end
      if ((p2y != p2y_q) && (p2_cnt_q != CntMax)) begin
        p2_cnt_d = p2_cnt_q + 1'b1;
      end
    end
  end

  // Counter state; reset has priority over cnt_clr with the same all-zero result.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_cnt_q <= '0;
      p2_cnt_q <= '0;
    end else begin
      p1_cnt_q <= p1_cnt_d;
      p2_cnt_q <= p2_cnt_d;
    end
  end

  assign p1_tog_cnt = p1_cnt_q;
  assign p2_tog_cnt = p2_cnt_q;
`else
  // Width parameter only matters when the counters are compiled in.
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule : dual_nand4

// File: tb/tb_dual_nand4.sv
// Self-checking bench for dual_nand4: behavioural model plus directed literal checks.
module tb_dual_nand4;

  localparam int unsigned CntW    = 16;
  localparam int unsigned SatW    = 2;
  localparam int          MainMax = (1 << CntW) - 1;
  localparam int          SatMax  = (1 << SatW) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in1 = 4'h0;
  logic [3:0] in2 = 4'h0;
  logic       p1y, p2y, p1y_q, p2y_q;
  logic       chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef DUAL_NAND4_TOGGLE_CNT_EN
  logic            cnt_clr = 1'b0;
  logic [CntW-1:0] p1_tog_cnt, p2_tog_cnt;
  logic [SatW-1:0] s1_tog_cnt, s2_tog_cnt;
  logic            s1y, s2y, s1y_q, s2y_q;
`endif

  dual_nand4 #(
    .CNT_W (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p1a        (in1[3]),
    .p1b        (in1[2]),
    .p1c        (in1[1]),
    .p1d        (in1[0]),
    .p2a        (in2[3]),
    .p2b        (in2[2]),
    .p2c        (in2[1]),
    .p2d        (in2[0]),
    .p1y        (p1y),
    .p2y        (p2y),
    .p1y_q      (p1y_q),
    .p2y_q      (p2y_q)
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .p1_tog_cnt (p1_tog_cnt),
    .p2_tog_cnt (p2_tog_cnt)
`endif
  );

`ifdef DUAL_NAND4_TOGGLE_CNT_EN
  // Narrow-counter instance sharing all stimulus, used for saturation.
  dual_nand4 #(
    .CNT_W (SatW)
  ) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .p1a        (in1[3]),
    .p1b        (in1[2]),
    .p1c        (in1[1]),
    .p1d        (in1[0]),
    .p2a        (in2[3]),
    .p2b        (in2[2]),
    .p2c        (in2[1]),
    .p2d        (in2[0]),
    .p1y        (s1y),
    .p2y        (s2y),
    .p1y_q      (s1y_q),
    .p2y_q      (s2y_q),
    .cnt_clr    (cnt_clr),
    .p1_tog_cnt (s1_tog_cnt),
    .p2_tog_cnt (s2_tog_cnt)
  );
`endif

  function automatic logic nand_ref(input logic [3:0] v);
    return (v == 4'b1111) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the clocked stage.
  logic m1_q, m2_q;
  int   m1_cnt = 0, m2_cnt = 0, ms1_cnt = 0, ms2_cnt = 0;

  always @(posedge clk) begin
    logic n1, n2, clr;
    n1 = nand_ref(in1);
    n2 = nand_ref(in2);
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
    clr = cnt_clr;
`else
    clr = 1'b0;
`endif
    if (reset || clr) begin
      m1_cnt  <= 0;
      m2_cnt  <= 0;
      ms1_cnt <= 0;
      ms2_cnt <= 0;
    end else begin
      if (n1 != m1_q) begin
        m1_cnt  <= (m1_cnt + 1 > MainMax) ? MainMax : m1_cnt + 1;
        ms1_cnt <= (ms1_cnt + 1 > SatMax) ? SatMax : ms1_cnt + 1;
      end
      if (n2 != m2_q) begin
        m2_cnt  <= (m2_cnt + 1 > MainMax) ? MainMax : m2_cnt + 1;
        ms2_cnt <= (ms2_cnt + 1 > SatMax) ? SatMax : ms2_cnt + 1;
      end
    end
    m1_q <= reset ? 1'b1 : n1;
    m2_q <= reset ? 1'b1 : n2;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_p1y", {31'd0, p1y}, {31'd0, nand_ref(in1)});
      chk("model_p2y", {31'd0, p2y}, {31'd0, nand_ref(in2)});
      chk("model_p1y_q", {31'd0, p1y_q}, {31'd0, m1_q});
      chk("model_p2y_q", {31'd0, p2y_q}, {31'd0, m2_q});
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
      chk("model_p1_cnt", {16'd0, p1_tog_cnt}, m1_cnt);
      chk("model_p2_cnt", {16'd0, p2_tog_cnt}, m2_cnt);
      chk("model_s1_cnt", {30'd0, s1_tog_cnt}, ms1_cnt);
      chk("model_s2_cnt", {30'd0, s2_tog_cnt}, ms2_cnt);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c2;
    // Reset both registers, then enable the model compare.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Counting sweep with literal expectations.
    for (int cnt = 0; cnt < 20; cnt++) begin
      @(negedge clk);
      #2;
      c2  = 4'(cnt + 1);
      in1 = 4'(cnt);
      in2 = c2;
      #1;
      chk("sweep_p1y", {31'd0, p1y}, (cnt == 15) ? 32'd0 : 32'd1);
      chk("sweep_p2y", {31'd0, p2y}, (cnt == 14) ? 32'd0 : 32'd1);
    end

    // Random vectors on both edges; zero-latency combinational checks.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      {in1, in2} = 8'($urandom);
      reset = ($urandom_range(0, 31) == 0);
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
      cnt_clr = ($urandom_range(0, 7) == 0);
`endif
      #1;
      chk("rand_p1y", {31'd0, p1y}, {31'd0, nand_ref(in1)});
      chk("rand_p2y", {31'd0, p2y}, {31'd0, nand_ref(in2)});
      @(negedge clk);
      #2;
      {in1, in2} = 8'($urandom);
      #1;
      chk("rand_p1y", {31'd0, p1y}, {31'd0, nand_ref(in1)});
      chk("rand_p2y", {31'd0, p2y}, {31'd0, nand_ref(in2)});
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
`ifdef DUAL_NAND4_TOGGLE_CNT_EN
    cnt_clr = 1'b0;
`endif

    // Reset for 2 cycles with all inputs high.
    @(negedge clk);
    #2;
    in1 = 4'hF;
    in2 = 4'hF;
    reset = 1'b1;
    #1;
    chk("rst_p1y_imm", {31'd0, p1y}, 32'd0);
    chk("rst_p2y_imm", {31'd0, p2y}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_p1y_q_edge", {31'd0, p1y_q}, 32'd1);
    chk("rst_p2y_q_edge", {31'd0, p2y_q}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_p1y_q_hold", {31'd0, p1y_q}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_p1y_q", {31'd0, p1y_q}, 32'd0);
    chk("rel_p2y_q", {31'd0, p2y_q}, 32'd0);

    // Registered latency: 1111 -> 0111 on gate 1.
    @(negedge clk);
    #2 in1 = 4'b0111;
    #1;
    chk("lat_p1y_imm", {31'd0, p1y}, 32'd1);
    chk("lat_p1y_q_old", {31'd0, p1y_q}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_p1y_q_new", {31'd0, p1y_q}, 32'd1);

`ifdef DUAL_NAND4_TOGGLE_CNT_EN
    // Toggle counters: clear edge discards the setup change, then 10 toggles.
    @(negedge clk);
    #2;
    in1 = 4'hF;
    in2 = 4'h0;
    cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2 in1 = ~in1;
      @(posedge clk);
    end
    #1;
    chk("tog_p1_cnt", {16'd0, p1_tog_cnt}, 32'd10);
    chk("tog_p2_cnt", {16'd0, p2_tog_cnt}, 32'd0);
    chk("sat_s1_cnt", {30'd0, s1_tog_cnt}, 32'd3);
    @(negedge clk);
    #2 cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_p1_cnt", {16'd0, p1_tog_cnt}, 32'd0);
    chk("clr_p2_cnt", {16'd0, p2_tog_cnt}, 32'd0);
    @(negedge clk);
    #2 cnt_clr = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dual_nand4
